// File: rtl/lane_pkg.sv
// Shared lane constants and the serialiser byte-index type, used by the
// unpacker, the 6-way demultiplexer and the upstream DMA sequencer.
package lane_pkg;

  localparam int LANE_W         = 25;
  localparam int DATA_W         = 24;
  localparam int BYTES_PER_WORD = 3;
  localparam int EN_BIT         = 0;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } byte_idx_t;

  // Select one byte of a stored word, most significant byte first.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] word,
                                           input byte_idx_t idx);
    logic [7:0] b;
    case (idx)
      B0:      b = word[23:16];
      B1:      b = word[15:8];
      B2:      b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lane_word_fifo.sv
// DEPTH x 24-bit word FIFO. A write is taken when there is room, or when the
// head word retires in the same cycle so the freed slot is reused at once.
module lane_word_fifo
  import lane_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic              do_pop;
  logic              wr_accept;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign do_pop    = pop && !empty;
  assign wr_accept = wr_req && (!full || do_pop);
  assign rd_data   = mem[rd_ptr];
  assign level     = level_q;

  // Storage array; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy: a write paired with a pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      case ({wr_accept, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/lane_byte_unpacker.sv
// Per-lane unpacker: buffers strobed 24-bit words from one demux output and
// emits each as three bytes (MSB first) on a valid/ready stream.
//
// Handshake: a byte moves when byte_valid && byte_ready at a rising edge.
// Once byte_valid is high, byte_out and the byte index hold until that
// transfer happens; byte_valid never drops without a transfer.
module lane_byte_unpacker
  import lane_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANE_W-1:0]      lane_in,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  byte_idx_t         idx;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              retire;
  logic              reject;

  assign wr_req     = lane_in[EN_BIT];
  assign wr_data    = lane_in[LANE_W-1:1];
  assign byte_valid = !fifo_empty;
  assign xfer       = byte_valid && byte_ready;
  assign retire     = xfer && (idx == B2);
  // A full FIFO still accepts when the head leaves this cycle.
  assign reject     = wr_req && fifo_full && !retire;

  lane_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .pop     (retire),
    .rd_data (head_word),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serialiser byte index: advances only on a transfer, wraps after B2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= B0;
    end else if (xfer) begin
      case (idx)
        B0:      idx <= B1;
        B1:      idx <= B2;
        B2:      idx <= B0;
        default: idx <= B0;
      endcase
    end
  end

  // Byte select from the head word; idle bus reads as zero.
  always_comb begin
    byte_out = 8'h00;
    if (byte_valid) begin
      byte_out = pick_byte(head_word, idx);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (reject) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/lane_byte_unpacker.md
# lane_byte_unpacker

Per-lane consumer that sits directly downstream of one 25-bit output of the 6-way DMA demultiplexer. It captures each `{data[23:0], enable}` word whose enable bit is set into a small word FIFO. It then serialises each stored word into three bytes on a valid/ready byte stream toward the accelerator datapath. One instance is placed per demux output (six in total).

## Interface
Parameters:
- `DEPTH`, 4, number of 24-bit words buffered; power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lane_in`  in  25  demux output; `[24:1]` = 24-bit data (DMA word `[31:8]`), `[0]` = enable/write strobe (DMA word `[7]`).
- `byte_out`  out  8  current byte of head word.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ready`  in  1  sink accepts `byte_out` this cycle.
- `level`  out  `$clog2(DEPTH)+1`  words currently stored, counting a partially drained head word.
- `overflow`  out  1  sticky flag; a strobed word was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Write:
  - Every cycle with `lane_in[0]==1` is one write request carrying `lane_in[24:1]`.
  - The upstream sequencer guarantees a one-cycle strobe per DMA word. A strobe held for N cycles is N writes, by design.
  - A held non-selected demux output reads as all zeros and is ignored.
- Write accept condition: `level < DEPTH`, OR the head word retires this same cycle (byte index 2 accepted).
- Rejected write: data discarded, `overflow` set to 1 on the next edge, FIFO unchanged.
- Byte order is MSB first:
  - index 0 -> data `[23:16]`
  - index 1 -> data `[15:8]`
  - index 2 -> data `[7:0]`
- Serialiser:
  - 2-bit byte index `idx`, states `B0 -> B1 -> B2 -> B0`.
  - It advances only on transfer (`byte_valid && byte_ready`).
  - A transfer at B2 pops the head word and returns to B0.
- `byte_valid = (level != 0)`. `byte_out` = selected byte of the head word when valid, `8'h00` when empty.
- `byte_out` and `idx` are held stable while `byte_valid && !byte_ready` (no retraction).
- Simultaneous write and retiring pop: both take effect; `level` is unchanged.
- Simultaneous `clr_ovf` and a rejected write: set wins; `overflow` = 1.
- Pointers wrap modulo `DEPTH`; `level` saturates exactly at `DEPTH`, never beyond.
- Reset, including mid-word: `level`=0, pointers=0, `idx`=B0, `overflow`=0, `byte_valid`=0, `byte_out`=`8'h00`. Any partially drained word is discarded.

## Timing
- A write at edge N is visible: `byte_valid`=1 and the first byte on `byte_out` after edge N; `level` increments at the same edge.
- One byte per cycle under continuous `byte_ready`. A word drains in 3 cycles, so sustained input is at most one word per 3 cycles.
- `level` decrements on the edge of the index-2 transfer.
- `byte_valid` and `byte_out` derive from registers plus the memory read mux. There is no combinational path from `byte_ready` or `lane_in` to any output.
- `overflow` is registered: 1-cycle latency from the rejected strobe.

## Structure
- Shared package `lane_pkg` holds:
  - `LANE_W=25`, `DATA_W=24`, `BYTES_PER_WORD=3`, `EN_BIT=0`
  - the byte-index enum `{B0,B1,B2}`
- These constants are also consumed by the demux and the upstream DMA sequencer.
- One sub-module, `lane_word_fifo`: `DEPTH` x 24 register array with read/write pointers, `level`, full/empty, and the accept-on-retire rule.
- The top level contains the serialiser FSM, byte select and overflow flag.

## Test plan
- Reset, then a single write of `lane_in={24'hA1B2C3,1'b1}` with `byte_ready`=1 -> bytes `A1`,`B2`,`C3` on 3 consecutive cycles. `level` goes 1 then 0; `byte_valid` falls after `C3`.
- Backpressure: one word `24'h112233`, `byte_ready` toggling 1,0,0,1,1 -> `byte_out` holds `22` while stalled. Sequence is `11`,`22`,`33` with no duplication or loss.
- Fill (`DEPTH`=4) with 5 strobes, `byte_ready`=0 -> `level`=4, `overflow`=1 one cycle after the 5th. Draining yields exactly the first 4 words; `clr_ovf` then clears the flag.
- Full FIFO and a write coinciding with the head's `B2` transfer -> write accepted, `level` stays 4, `overflow` stays 0.
- Write with `lane_in[0]`=0 and data `24'hFFFFFF` -> no capture, `level`=0. Assert `rst` mid-word after byte `B1` -> all outputs return to their reset values asynchronously.
